i2c_slave_mem: RTL

- Synthesizable I2C target (responder) that acts as the far end of the team's I2C master. It emulates a 24Cxx-style EEPROM with 16-bit word addressing and an on-chip byte memory.
- Used in board-level loopback and in system simulation. It lets the UART-to-I2C bridge be exercised without an external EEPROM.
- Supports byte/page write, current-address read, random read (via repeated START) and sequential read.

---
 rtl/i2c_slave_mem.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_mem.sv
// I2C target emulating a 24Cxx-style EEPROM: 16-bit word pointer, on-chip
// byte memory, page writes wrapping inside a page, and current-address,
// random and sequential reads. SDA is open-drain (0 or z), never driven high.
// Bus protocol: the master owns SCL; this block only samples SDA on synced
// SCL rise and only changes its SDA drive one Clk after a synced SCL fall.
module i2c_slave_mem #(
  parameter logic [6:0] DEVICE_ID = 7'b1010000,
  parameter int         MEM_AW    = 8,
  parameter int         PAGE_AW   = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic        busy,
  output logic        wr_done,
  output logic [15:0] word_addr,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADDR  = 4'd1,
    ACK_DEV   = 4'd2,
    ADDR_HI   = 4'd3,
    ACK_HI    = 4'd4,
    ADDR_LO   = 4'd5,
    ACK_LO    = 4'd6,
    WR_DATA   = 4'd7,
    ACK_WR    = 4'd8,
    RD_DATA   = 4'd9,
    RD_ACK    = 4'd10,
    WAIT_STOP = 4'd11
  } state_t;

  localparam int DEPTH = 2 ** MEM_AW;

  state_t               state;
  logic [2:0]           scl_q;      // [1:0] synchronizer, [2] history
  logic [2:0]           sda_q;
  logic [3:0]           bit_cnt;
  logic [7:0]           shreg;
  logic [7:0]           addr_hi;
  logic                 rw;
  logic                 sda_oe;     // 1 = pull SDA low
  logic                 wr_seen;    // a data byte was committed in this transfer
  logic [7:0]           mem [DEPTH];
  logic [MEM_AW-1:0]    mem_idx;
  logic [7:0]           rd_byte;
  logic [PAGE_AW-1:0]   pg_next;
  logic                 scl_s, sda_s;
  logic                 scl_rise, scl_fall, start_det, stop_det, mem_we;

  assign i2c_sdat  = sda_oe ? 1'b0 : 1'bz;
  assign dbg_state = state;

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_s & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_s & sda_q[1] & ~sda_q[2];

  assign mem_idx   = word_addr[MEM_AW-1:0];
  assign rd_byte   = mem[mem_idx];
  assign pg_next   = word_addr[PAGE_AW-1:0] + {{(PAGE_AW-1){1'b0}}, 1'b1};
  // The 8th data bit is taken straight from the line so the byte commits on that rise.
  assign mem_we    = (state == WR_DATA) && scl_rise && (bit_cnt == 4'd7)
                     && !start_det && !stop_det;

  // Synchronize SCL/SDA; reset to the idle-high bus level so no false edges appear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], i2c_sclk};
      sda_q <= {sda_q[1:0], i2c_sdat};
    end
  end

  // Byte memory; deliberately not touched by reset.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_idx] <= {shreg[6:0], sda_s};
  end

  // Protocol FSM: START/STOP override everything, then SCL rise samples, SCL fall drives.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      addr_hi   <= 8'd0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
      wr_seen   <= 1'b0;
      word_addr <= 16'd0;
    end else begin
      wr_done <= 1'b0;
      if (start_det) begin
        state   <= DEV_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        wr_seen <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        wr_done <= wr_seen;
        wr_seen <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA: begin
            if (bit_cnt < 4'd8) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == WR_DATA && bit_cnt == 4'd7) wr_seen <= 1'b1;
          end
          RD_DATA: bit_cnt <= bit_cnt + 4'd1;
          RD_ACK: begin
            // Master ACK continues the sequential read, NACK ends it.
            if (sda_s) state <= WAIT_STOP;
            else       word_addr <= word_addr + 16'd1;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          DEV_ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (shreg[7:1] == DEVICE_ID) begin
              busy   <= 1'b1;
              rw     <= shreg[0];
              sda_oe <= 1'b1;
              state  <= ACK_DEV;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          ACK_DEV: begin
            bit_cnt <= 4'd0;
            if (rw) begin
              state  <= RD_DATA;
              shreg  <= rd_byte;
              sda_oe <= ~rd_byte[7];
            end else begin
              state  <= ADDR_HI;
              sda_oe <= 1'b0;
            end
          end
          ADDR_HI: if (bit_cnt == 4'd8) begin
            addr_hi <= shreg;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b1;
            state   <= ACK_HI;
          end
          ACK_HI: begin
            sda_oe <= 1'b0;
            state  <= ADDR_LO;
          end
          ADDR_LO: if (bit_cnt == 4'd8) begin
            // Pointer changes only once both address bytes have arrived.
            word_addr <= {addr_hi, shreg};
            bit_cnt   <= 4'd0;
            sda_oe    <= 1'b1;
            state     <= ACK_LO;
          end
          ACK_LO: begin
            sda_oe <= 1'b0;
            state  <= WR_DATA;
          end
          WR_DATA: if (bit_cnt == 4'd8) begin
            word_addr <= {word_addr[15:PAGE_AW], pg_next};
            bit_cnt   <= 4'd0;
            sda_oe    <= 1'b1;
            state     <= ACK_WR;
          end
          ACK_WR: begin
            sda_oe <= 1'b0;
            state  <= WR_DATA;
          end
          RD_DATA: begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= RD_ACK;
            end else begin
              sda_oe <= ~shreg[6];
              shreg  <= {shreg[6:0], 1'b0};
            end
          end
          RD_ACK: begin
            // Only reached after an ACK; word_addr already points at the next byte.
            bit_cnt <= 4'd0;
            shreg   <= rd_byte;
            sda_oe  <= ~rd_byte[7];
            state   <= RD_DATA;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
